// File: rtl/mux16_pkg.sv
// Shared constants, state encoding and helpers for the 16-input round-robin scheduler.
package mux16_pkg;

    localparam int unsigned N_IN  = 16;
    localparam int unsigned SEL_W = 4;

    typedef enum logic {
        IDLE,
        SERVE
    } state_t;

    // One-hot decode of a mux select value.
    function automatic logic [N_IN-1:0] onehot16(input logic [SEL_W-1:0] idx);
        logic [N_IN-1:0] ret;
        ret      = '0;
        ret[idx] = 1'b1;
        return ret;
    endfunction

endpackage

// File: rtl/mux_16to1.sv
// 16:1 datapath multiplexer steered by the scheduler select.
module mux_16to1 #(
    parameter int unsigned W = 8
) (
    input  logic [15:0][W-1:0] din,
    input  logic [3:0]         sel,
    output logic [W-1:0]       dout
);

    // Pure selection; no storage in the datapath.
    always_comb begin
        dout = din[sel];
    end

endmodule

// File: rtl/rr_pick16.sv
// Rotating priority picker: first set request bit at or after start, wrapping mod 16.
module rr_pick16
    import mux16_pkg::*;
(
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    // Walk the 16 positions starting at start; the first hit wins.
    always_comb begin
        logic [SEL_W-1:0] pos;
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            pos = start + SEL_W'(i);
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/mux16_rr_scheduler.sv
// Round-robin scheduler sharing a 16:1 mux among 16 requesters with bounded bursts
// and a valid/ready handshake toward the downstream consumer. All outputs registered.
module mux16_rr_scheduler
    import mux16_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  req,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic [N_IN-1:0]  grant,
    output logic             out_valid,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_IN-1:0]  grant_q, grant_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [SEL_W-1:0] last_ptr_q, last_ptr_d;

    logic [SEL_W-1:0] pick_start;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             beat;
    logic             release_now;

    // Search starts just past the previous owner: last_ptr while idle, the current
    // select while serving (last_ptr only catches up at release).
    always_comb begin
        pick_start = (state_q == SERVE) ? (sel_q + 1'b1) : (last_ptr_q + 1'b1);
    end

    rr_pick16 u_pick (
        .req   (req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Beat detection and release condition for the current owner.
    always_comb begin
        beat        = out_valid_q & out_ready;
        release_now = !req[sel_q] || (beat && (burst_cnt_q == LAST_BEAT));
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        grant_d     = grant_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        burst_cnt_d = burst_cnt_q;
        last_ptr_d  = last_ptr_q;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = SERVE;
                    sel_d       = pick_idx;
                    grant_d     = onehot16(pick_idx);
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    burst_cnt_d = '0;
                end
            end
            SERVE: begin
                if (release_now) begin
                    last_ptr_d  = sel_q;
                    burst_cnt_d = '0;
                    if (pick_found) begin
                        sel_d       = pick_idx;
                        grant_d     = onehot16(pick_idx);
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        grant_d     = '0;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                    end
                end else if (beat) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            burst_cnt_q <= '0;
            last_ptr_q  <= SEL_W'(N_IN - 1);
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            burst_cnt_q <= burst_cnt_d;
            last_ptr_q  <= last_ptr_d;
        end
    end

    // Ports come straight from flops.
    always_comb begin
        sel       = sel_q;
        grant     = grant_q;
        out_valid = out_valid_q;
        busy      = busy_q;
    end

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Directed bench for mux16_rr_scheduler with the mux_16to1 datapath attached.
module tb_mux16_rr_scheduler;

    logic             clk;
    logic             rst;
    logic [15:0]      req;
    logic             out_ready;
    logic [3:0]       sel;
    logic [15:0]      grant;
    logic             out_valid;
    logic             busy;
    logic [15:0][7:0] din;
    logic [7:0]       dout;

    int n_cmp;
    int n_bad;

    mux16_rr_scheduler #(.MAX_BURST(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .busy      (busy)
    );

    mux_16to1 #(.W(8)) u_mux (
        .din  (din),
        .sel  (sel),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int unsigned i);
        return 8'((i * 37 + 5) & 255);
    endfunction

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Checks the four outputs, the burst counter and the mux data against expectations.
    task automatic expect_srv(input string nm, input logic [3:0] es, input logic [2:0] ec);
        logic [15:0] eg;
        eg = 16'd1 << es;
        n_cmp++;
        if (sel !== es || grant !== eg || out_valid !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: sel=%0d grant=%h v=%b b=%b want sel=%0d grant=%h v=1 b=1",
                     nm, sel, grant, out_valid, busy, es, eg);
        end
        n_cmp++;
        if (dut.burst_cnt_q !== ec) begin
            n_bad++;
            $display("FAIL %s_cnt: got %0d want %0d", nm, dut.burst_cnt_q, ec);
        end
        n_cmp++;
        if (dout !== pat(32'(es))) begin
            n_bad++;
            $display("FAIL %s_data: got %h want %h", nm, dout, pat(32'(es)));
        end
    endtask

    task automatic expect_idle(input string nm, input logic chk_sel);
        n_cmp++;
        if (grant !== 16'h0 || out_valid !== 1'b0 || busy !== 1'b0 || (chk_sel && sel !== 4'd0)) begin
            n_bad++;
            $display("FAIL %s: sel=%0d grant=%h v=%b b=%b want sel=0 grant=0000 v=0 b=0",
                     nm, sel, grant, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            expect_idle("t1_idle", 1'b1);
            tick();
        end
    endtask

    task automatic test_sole_requester();
        do_reset();
        req       = 16'h0002;
        out_ready = 1'b1;
        tick();
        for (int k = 0; k < 9; k++) begin
            expect_srv("t2_sole", 4'd1, 3'(k % 4));
            tick();
        end
    endtask

    task automatic test_alternate();
        do_reset();
        req       = 16'h8001;
        out_ready = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            expect_srv("t3_alt", ((k / 4) % 2 == 0) ? 4'd0 : 4'd15, 3'(k % 4));
            tick();
        end
    endtask

    task automatic test_stall();
        do_reset();
        req       = 16'h0420;
        out_ready = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            expect_srv("t4_stall", 4'd5, 3'd0);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_srv("t4_run", 4'd5, 3'(k));
            tick();
        end
        expect_srv("t4_next", 4'd10, 3'd0);
    endtask

    task automatic test_drop_req();
        do_reset();
        req       = 16'h0108;
        out_ready = 1'b1;
        tick();
        expect_srv("t5_grant", 4'd3, 3'd0);
        tick();
        tick();
        expect_srv("t5_two", 4'd3, 3'd2);
        req = 16'h0100;
        tick();
        expect_srv("t5_move", 4'd8, 3'd0);
        req = 16'h0000;
        tick();
        expect_idle("t5_idle", 1'b0);
        tick();
        expect_idle("t5_idle2", 1'b0);
    endtask

    task automatic test_async_reset();
        do_reset();
        req       = 16'h0200;
        out_ready = 1'b1;
        tick();
        tick();
        expect_srv("t6_pre", 4'd9, 3'd1);
        #2;
        rst = 1'b1;
        #1;
        expect_idle("t6_async", 1'b1);
        req = 16'hFFFF;
        tick();
        expect_idle("t6_held", 1'b1);
        rst = 1'b0;
        tick();
        for (int k = 0; k < 12; k++) begin
            expect_srv("t6_order", 4'(k / 4), 3'(k % 4));
            tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 16; i++) din[i] = pat(32'(i));
        test_reset();
        test_sole_requester();
        test_alternate();
        test_stall();
        test_drop_req();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
